// File: rtl/branch_target_buffer_if.sv
// Fetch/update bus of the branch target buffer.
//   master (fetch + execute side): drives cpc, flush and the upd_* resolution
//     fields, and receives the prediction and the statistics.
//   slave (the BTB): the mirror image.
// All addresses are word addresses (byte address [31:2]).
interface branch_target_buffer_if;
    logic [29:0] cpc;
    logic        bpSel;
    logic [29:0] bp_a;
    logic        flush;
    logic        upd_en;
    logic [29:0] upd_pc;
    logic        upd_taken;
    logic [29:0] upd_target;
    logic        upd_predtaken;
    logic [29:0] upd_predtarget;
    logic        mispredict;
    logic [15:0] upd_cnt;
    logic [15:0] miss_cnt;

    modport master (
        output cpc, flush, upd_en, upd_pc, upd_taken, upd_target,
               upd_predtaken, upd_predtarget,
        input  bpSel, bp_a, mispredict, upd_cnt, miss_cnt
    );

    modport slave (
        input  cpc, flush, upd_en, upd_pc, upd_taken, upd_target,
               upd_predtaken, upd_predtarget,
        output bpSel, bp_a, mispredict, upd_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
//   CLK  : sole clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : slave side of branch_target_buffer_if
//          lookup  : cpc -> bpSel / bp_a (combinational)
//          update  : upd_* from execute, written on the rising edge
//          flush   : invalidates every entry at the next edge
//          stats   : mispredict (combinational), upd_cnt, miss_cnt (saturating)
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    branch_target_buffer_if.slave bus
);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [29:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [15:0]        upd_cnt_q;
    logic [15:0]        miss_cnt_q;

    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               rd_hit;
    logic               wr_hit;
    logic [1:0]         ctr_nxt;
    logic               mis;

    // Lookup reads the registered table only, so an update in the same
    // cycle is not visible until after the edge.
    assign rd_idx = bus.cpc[IDX_W-1:0];
    assign rd_hit = valid[rd_idx] && (tag_q[rd_idx] == bus.cpc[29:IDX_W]);

    assign bus.bpSel = rd_hit && ctr_q[rd_idx][1];
    assign bus.bp_a  = rd_hit ? tgt_q[rd_idx] : '0;

    assign wr_idx = bus.upd_pc[IDX_W-1:0];
    assign wr_hit = valid[wr_idx] && (tag_q[wr_idx] == bus.upd_pc[29:IDX_W]);

    // A wrong target only counts when the branch was actually taken.
    assign mis = bus.upd_en &&
                 ((bus.upd_taken != bus.upd_predtaken) ||
                  (bus.upd_taken && (bus.upd_target != bus.upd_predtarget)));
    assign bus.mispredict = mis;

    always_comb begin
        ctr_nxt = ctr_q[wr_idx];
        if (bus.upd_taken) begin
            if (ctr_q[wr_idx] != 2'b11) ctr_nxt = ctr_q[wr_idx] + 2'b01;
        end else begin
            if (ctr_q[wr_idx] != 2'b00) ctr_nxt = ctr_q[wr_idx] - 2'b01;
        end
    end

    // Valid bits and counters carry reset; flush only drops the valid bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
        end else if (bus.flush) begin
            valid <= '0;
        end else if (bus.upd_en) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_nxt;
            end else if (bus.upd_taken) begin
                valid[wr_idx] <= 1'b1;
                ctr_q[wr_idx] <= 2'b10;
            end
        end
    end

    // Tag/target storage needs no reset: it is only observed behind valid.
    // A taken update writes both on hit (tag unchanged) and on allocation.
    always_ff @(posedge CLK) begin
        if (!RST && !bus.flush && bus.upd_en && bus.upd_taken) begin
            tgt_q[wr_idx] <= bus.upd_target;
            tag_q[wr_idx] <= bus.upd_pc[29:IDX_W];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            upd_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (bus.upd_en && (upd_cnt_q != 16'hFFFF)) upd_cnt_q  <= upd_cnt_q + 16'd1;
            if (mis && (miss_cnt_q != 16'hFFFF))       miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign bus.upd_cnt  = upd_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    branch_target_buffer_if bus();

    branch_target_buffer #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: a map from index to the last allocated word address,
    // its target and a 0..3 confidence level.
    typedef struct {
        logic [29:0] pc;
        logic [29:0] target;
        int          ctr;
    } ent_t;

    ent_t tbl [int];
    int   m_upd;
    int   m_miss;

    typedef struct {
        string       name;
        logic        bpSel;
        logic [29:0] bp_a;
        logic        mis;
        logic [15:0] uc;
        logic [15:0] mc;
    } exp_t;

    exp_t sb [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic bit lookup(input logic [29:0] a, output logic [29:0] tgt, output int ctr);
        int i;
        i   = int'(a % 30'(ENTRIES));
        tgt = '0;
        ctr = 0;
        if (tbl.exists(i) && ((tbl[i].pc >> IDX_W) == (a >> IDX_W))) begin
            tgt = tbl[i].target;
            ctr = tbl[i].ctr;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        tbl.delete();
        m_upd  = 0;
        m_miss = 0;
    endtask

    task automatic model_edge(input logic fl, input logic en, input logic [29:0] pc,
                              input logic tk, input logic [29:0] tg, input logic mis);
        int          i;
        logic [29:0] t;
        int          c;
        ent_t        e;
        if (en && m_upd < 65535) m_upd++;
        if (mis && m_miss < 65535) m_miss++;
        if (fl) begin
            tbl.delete();
        end else if (en) begin
            i = int'(pc % 30'(ENTRIES));
            if (lookup(pc, t, c)) begin
                e = tbl[i];
                e.ctr = tk ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
                if (tk) e.target = tg;
                tbl[i] = e;
            end else if (tk) begin
                e.pc = pc; e.target = tg; e.ctr = 2;
                tbl[i] = e;
            end
        end
    endtask

    // One clock cycle of stimulus: entered at posedge+1, drives inputs,
    // queues the expected outputs for this cycle, then advances the model
    // across the edge.
    task automatic cycle(input string nm, input logic rst, input logic [29:0] cpc,
                         input logic fl, input logic en, input logic [29:0] pc,
                         input logic tk, input logic [29:0] tg,
                         input logic pt, input logic [29:0] ptg);
        exp_t        e;
        logic [29:0] t;
        int          c;
        bit          h;
        bus.cpc            = cpc;
        bus.flush          = fl;
        bus.upd_en         = en;
        bus.upd_pc         = pc;
        bus.upd_taken      = tk;
        bus.upd_target     = tg;
        bus.upd_predtaken  = pt;
        bus.upd_predtarget = ptg;
        if (rst) begin
            #2;
            RST = 1'b1;
            model_reset();
        end else begin
            RST = 1'b0;
        end
        h       = lookup(cpc, t, c);
        e.name  = nm;
        e.bpSel = h && (c >= 2);
        e.bp_a  = h ? t : 30'd0;
        e.mis   = en && ((tk != pt) || (tk && (tg != ptg)));
        e.uc    = 16'(m_upd);
        e.mc    = 16'(m_miss);
        sb.push_back(e);
        @(posedge CLK);
        if (!rst) model_edge(fl, en, pc, tk, tg, e.mis);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: samples the DUT mid-cycle and retires one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".bpSel"},      32'(bus.bpSel),      32'(e.bpSel));
                chk({e.name, ".bp_a"},       32'(bus.bp_a),       32'(e.bp_a));
                chk({e.name, ".mispredict"}, 32'(bus.mispredict), 32'(e.mis));
                chk({e.name, ".upd_cnt"},    32'(bus.upd_cnt),    32'(e.uc));
                chk({e.name, ".miss_cnt"},   32'(bus.miss_cnt),   32'(e.mc));
            end
        end
    end

    function automatic logic [29:0] pool_pc();
        return 30'(($urandom_range(0, 2) << IDX_W) | $urandom_range(0, 3));
    endfunction

    initial begin
        logic [29:0] cpc, pc, tg, ptg, t;
        logic        fl, en, tk, pt, rr;
        int          c;
        bit          h;
        int          waits;

        model_reset();
        @(posedge CLK);
        #1;

        // Reset, then idle lookups on a fresh table.
        cycle("rst0",   1, 30'h100, 0, 1, 30'h100, 1, 30'h200, 0, 30'h0);
        cycle("rst1",   1, 30'h100, 0, 0, 30'h0,   0, 30'h0,   0, 30'h0);
        cycle("idle",   0, 30'h100, 0, 0, 30'h0,   0, 30'h0,   0, 30'h0);

        // Allocation on a taken miss, then a hit predicting taken.
        cycle("alloc",  0, 30'h100, 0, 1, 30'h100, 1, 30'h200, 0, 30'h0);
        cycle("hit",    0, 30'h100, 0, 0, 30'h0,   0, 30'h0,   0, 30'h0);

        // Not-taken updates walk the counter down and saturate at zero.
        for (int k = 0; k < 3; k++)
            cycle("nt",  0, 30'h100, 0, 1, 30'h100, 0, 30'h0, 1, 30'h200);
        cycle("ntchk",  0, 30'h100, 0, 0, 30'h0,   0, 30'h0,   0, 30'h0);
        cycle("tk",     0, 30'h100, 0, 1, 30'h100, 1, 30'h200, 0, 30'h200);
        cycle("tk2",    0, 30'h100, 0, 1, 30'h100, 1, 30'h200, 0, 30'h200);

        // Alias at the same index replaces the older entry.
        cycle("alias",  0, 30'h110, 0, 1, 30'h110, 1, 30'h555, 0, 30'h0);
        cycle("alsA",   0, 30'h110, 0, 0, 30'h0,   0, 30'h0,   0, 30'h0);
        cycle("alsB",   0, 30'h100, 0, 0, 30'h0,   0, 30'h0,   0, 30'h0);

        // Flush wins over a simultaneous taken update.
        cycle("flush",  0, 30'h110, 1, 1, 30'h300, 1, 30'h444, 0, 30'h0);
        cycle("fl300",  0, 30'h300, 0, 0, 30'h0,   0, 30'h0,   0, 30'h0);
        cycle("fl110",  0, 30'h110, 0, 0, 30'h0,   0, 30'h0,   0, 30'h0);

        // Reset arriving during an update discards it.
        cycle("pre",    0, 30'h120, 0, 1, 30'h120, 1, 30'h777, 0, 30'h0);
        cycle("rstupd", 1, 30'h120, 0, 1, 30'h130, 1, 30'h123, 0, 30'h0);
        cycle("post1",  0, 30'h130, 0, 0, 30'h0,   0, 30'h0,   0, 30'h0);
        cycle("post2",  0, 30'h120, 0, 0, 30'h0,   0, 30'h0,   0, 30'h0);

        // Randomized traffic over a small aliasing address pool.
        for (int k = 0; k < 3000; k++) begin
            cpc = ($urandom_range(0, 3) != 0) ? pool_pc() : 30'($urandom);
            pc  = pool_pc();
            fl  = ($urandom_range(0, 99) < 3);
            rr  = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) < 6);
            tk  = $urandom_range(0, 1);
            tg  = ($urandom_range(0, 1) != 0) ? 30'($urandom_range(0, 3) * 16) : 30'($urandom);
            if ($urandom_range(0, 1) != 0) begin
                h   = lookup(pc, t, c);
                pt  = h && (c >= 2);
                ptg = h ? t : 30'd0;
            end else begin
                pt  = $urandom_range(0, 1);
                ptg = tg ^ 30'($urandom_range(0, 1));
            end
            cycle("rand", rr, cpc, fl, en, pc, tk, tg, pt, ptg);
        end

        // Drive the miss counter into saturation and past it.
        for (int k = 0; k < 65537; k++)
            cycle("sat", 0, pool_pc(), 0, 1, pool_pc(), 1, 30'h5, 0, 30'h5);
        cycle("satchk", 0, 30'h100, 0, 0, 30'h0, 0, 30'h0, 0, 30'h0);

        waits = 0;
        while (sb.size() > 0 && waits < 10) begin
            @(posedge CLK);
            waits++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
